// File: rtl/vga_color_pipe_pkg.sv
// Shared types and constants for the VGA colour pipeline: component width,
// palette entry layout, write-port enums and the default C64 palette.
package vga_color_pipe_pkg;

    localparam int unsigned COMP_W      = 6;
    localparam int unsigned PAL_ENTRIES = 16;

    typedef struct packed {
        logic [COMP_W-1:0] r;
        logic [COMP_W-1:0] g;
        logic [COMP_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } pal_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        GOT_R,
        GOT_G,
        PENDING
    } wr_state_e;

    // C64 palette scaled from 8-bit to 6-bit components
    localparam rgb_t DEFAULT_PAL [PAL_ENTRIES] = '{
        '{6'd0,  6'd0,  6'd0 },
        '{6'd63, 6'd63, 6'd63},
        '{6'd26, 6'd13, 6'd10},
        '{6'd28, 6'd41, 6'd44},
        '{6'd27, 6'd15, 6'd33},
        '{6'd22, 6'd35, 6'd16},
        '{6'd13, 6'd10, 6'd30},
        '{6'd46, 6'd49, 6'd27},
        '{6'd27, 6'd19, 6'd9 },
        '{6'd16, 6'd14, 6'd0 },
        '{6'd38, 6'd25, 6'd22},
        '{6'd17, 6'd17, 6'd17},
        '{6'd27, 6'd27, 6'd27},
        '{6'd38, 6'd52, 6'd33},
        '{6'd27, 6'd23, 6'd45},
        '{6'd37, 6'd37, 6'd37}
    };

    function automatic rgb_t default_entry(input int unsigned i);
        return DEFAULT_PAL[i % PAL_ENTRIES];
    endfunction

endpackage

// File: rtl/vga_color_pipe_palette_ram.sv
// Single-clock palette RAM: one write port, one registered read port
// (read-before-write), reloaded with the default palette on reset.
module palette_ram
    import vga_color_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 6,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3*W-1:0]   wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3*W-1:0]   rd_data
);

    logic [3*W-1:0] mem [DEPTH];

    function automatic logic [3*W-1:0] init_entry(input int unsigned i);
        rgb_t e;
        e = default_entry(i);
        return {W'(e.r), W'(e.g), W'(e.b)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= init_entry(i);
            end
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_idx];
            if (we) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/vga_color_pipe.sv
// Palette lookup, scanline dimming and blanking behind the scan doubler.
// Define VGA_PALETTE_WRITE_EN to enable the deferred palette write port.
module vga_color_pipe
    import vga_color_pipe_pkg::*;
#(
    parameter int unsigned PAL_DEPTH = 16,
    parameter int unsigned COMP_W    = 6
) (
    input  logic              clk_dot8x,
    input  logic              rst_n,
    input  logic [3:0]        pixel_color4,
    input  logic              active,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              half_bright,
    input  logic              pal_we,
    input  logic [1:0]        pal_sel,
    input  logic [3:0]        pal_idx,
    input  logic [COMP_W-1:0] pal_data,
    output logic              pal_busy,
    output logic [COMP_W-1:0] red,
    output logic [COMP_W-1:0] green,
    output logic [COMP_W-1:0] blue,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              active_o
);

    localparam int unsigned IDX_W = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;

    logic [IDX_W-1:0]    s1_idx;
    logic                s1_act, s1_hs, s1_vs, s1_hb;
    logic                s2_act, s2_hs, s2_vs, s2_hb;
    logic [3*COMP_W-1:0] rd_data;
    logic [COMP_W-1:0]   rd_r, rd_g, rd_b;

    logic                commit;
    logic [IDX_W-1:0]    w_idx;
    logic [COMP_W-1:0]   w_r, w_g, w_b;

    always_ff @(posedge clk_dot8x or negedge rst_n) begin
        if (!rst_n) begin
            s1_idx <= '0;
            s1_act <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_hb  <= 1'b0;
            s2_act <= 1'b0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_hb  <= 1'b0;
        end else begin
            s1_idx <= IDX_W'(32'(pixel_color4) % PAL_DEPTH);
            s1_act <= active;
            s1_hs  <= hsync;
            s1_vs  <= vsync;
            s1_hb  <= half_bright;
            s2_act <= s1_act;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_hb  <= s1_hb;
        end
    end

    palette_ram #(
        .DEPTH (PAL_DEPTH),
        .W     (COMP_W),
        .IDX_W (IDX_W)
    ) u_palette_ram (
        .clk     (clk_dot8x),
        .rst_n   (rst_n),
        .we      (commit),
        .wr_idx  (w_idx),
        .wr_data ({w_r, w_g, w_b}),
        .rd_idx  (s1_idx),
        .rd_data (rd_data)
    );

    assign {rd_r, rd_g, rd_b} = rd_data;

    always_ff @(posedge clk_dot8x or negedge rst_n) begin
        if (!rst_n) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            hsync_o  <= 1'b1;
            vsync_o  <= 1'b1;
            active_o <= 1'b0;
        end else begin
            red      <= s2_act ? (s2_hb ? (rd_r >> 1) : rd_r) : '0;
            green    <= s2_act ? (s2_hb ? (rd_g >> 1) : rd_g) : '0;
            blue     <= s2_act ? (s2_hb ? (rd_b >> 1) : rd_b) : '0;
            hsync_o  <= s2_hs;
            vsync_o  <= s2_vs;
            active_o <= s2_act;
        end
    end

`ifdef VGA_PALETTE_WRITE_EN
    wr_state_e state, state_nxt;
    logic      ld_r, ld_g, ld_b;

    always_ff @(posedge clk_dot8x or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w_idx <= '0;
            w_r   <= '0;
            w_g   <= '0;
            w_b   <= '0;
        end else begin
            state <= state_nxt;
            if (ld_r) begin
                w_idx <= IDX_W'(32'(pal_idx) % PAL_DEPTH);
                w_r   <= pal_data;
            end
            if (ld_g) w_g <= pal_data;
            if (ld_b) w_b <= pal_data;
        end
    end

    // A stray R mid-sequence restarts; any other out-of-order select aborts
    always_comb begin
        state_nxt = state;
        ld_r      = 1'b0;
        ld_g      = 1'b0;
        ld_b      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (pal_we && pal_sel == SEL_R) begin
                    ld_r      = 1'b1;
                    state_nxt = GOT_R;
                end
            end
            GOT_R: begin
                if (pal_we) begin
                    if (pal_sel == SEL_G) begin
                        ld_g      = 1'b1;
                        state_nxt = GOT_G;
                    end else if (pal_sel == SEL_R) begin
                        ld_r      = 1'b1;
                        state_nxt = GOT_R;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GOT_G: begin
                if (pal_we) begin
                    if (pal_sel == SEL_B) begin
                        ld_b      = 1'b1;
                        state_nxt = PENDING;
                    end else if (pal_sel == SEL_R) begin
                        ld_r      = 1'b1;
                        state_nxt = GOT_R;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            PENDING: begin
                if (!s1_act) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pal_busy = (state == PENDING);
`else
    logic unused_pal_port;

    assign unused_pal_port = ^{pal_we, pal_sel, pal_idx, pal_data};
    assign commit   = 1'b0;
    assign w_idx    = '0;
    assign w_r      = '0;
    assign w_g      = '0;
    assign w_b      = '0;
    assign pal_busy = 1'b0;
`endif

endmodule

// File: tb/tb_vga_color_pipe.sv
// Randomized self-checking bench for vga_color_pipe against a queue-based
// pixel model and a component-collecting palette write model.
module tb_vga_color_pipe;
    import vga_color_pipe_pkg::*;

`ifdef VGA_PALETTE_WRITE_EN
    localparam bit          WR_EN = 1'b1;
    localparam logic [17:0] EXP2  = {6'd5, 6'd6, 6'd7};
    localparam logic [17:0] EXP5  = {6'd10, 6'd11, 6'd12};
`else
    localparam bit          WR_EN = 1'b0;
    localparam logic [17:0] EXP2  = {6'd26, 6'd13, 6'd10};
    localparam logic [17:0] EXP5  = {6'd22, 6'd35, 6'd16};
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pixel_color4;
    logic       active, hsync, vsync, half_bright;
    logic       pal_we;
    logic [1:0] pal_sel;
    logic [3:0] pal_idx;
    logic [5:0] pal_data;
    logic       pal_busy;
    logic [5:0] red, green, blue;
    logic       hsync_o, vsync_o, active_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_color_pipe #(
        .PAL_DEPTH (16),
        .COMP_W    (6)
    ) dut (
        .clk_dot8x    (clk),
        .rst_n        (rst_n),
        .pixel_color4 (pixel_color4),
        .active       (active),
        .hsync        (hsync),
        .vsync        (vsync),
        .half_bright  (half_bright),
        .pal_we       (pal_we),
        .pal_sel      (pal_sel),
        .pal_idx      (pal_idx),
        .pal_data     (pal_data),
        .pal_busy     (pal_busy),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .active_o     (active_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pixels in flight, palette contents, collected write components
    typedef struct {
        logic [3:0]  idx;
        logic        act, hs, vs, hb;
        logic [17:0] col;
    } pix_t;

    pix_t        pq[$];
    logic [17:0] m_pal [16];
    int          m_cnt;
    logic [3:0]  m_idx;
    logic [5:0]  m_c [3];
    bit          m_pend;

    function automatic void model_reset();
        pix_t p;
        p = '{idx: 4'd0, act: 1'b0, hs: 1'b1, vs: 1'b1, hb: 1'b0, col: 18'd0};
        pq.delete();
        pq.push_back(p);
        pq.push_back(p);
        for (int i = 0; i < 16; i++) m_pal[i] = DEFAULT_PAL[i];
        m_cnt  = 0;
        m_pend = 0;
    endfunction

    function automatic logic [17:0] shade(input pix_t p);
        logic [5:0] r, g, b;
        r = p.col[17:12];
        g = p.col[11:6];
        b = p.col[5:0];
        if (!p.act) return 18'd0;
        if (p.hb) begin
            r = r / 2;
            g = g / 2;
            b = b / 2;
        end
        return {r, g, b};
    endfunction

    function automatic void model_write(input logic [1:0] sel, input logic [3:0] idx, input logic [5:0] d);
        if (sel == 2'd0) begin
            m_idx  = idx;
            m_c[0] = d;
            m_cnt  = 1;
        end else if (m_cnt > 0 && int'(sel) == m_cnt) begin
            m_c[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 3) begin
                m_pend = 1;
                m_cnt  = 0;
            end
        end else begin
            m_cnt = 0;
        end
    endfunction

    task automatic tick();
        pix_t  t, o;
        bit    pend_before;
        @(posedge clk);
        t = pq[pq.size()-1];
        t.col = m_pal[t.idx];
        pq[pq.size()-1] = t;
        pend_before = m_pend;
        if (m_pend && !t.act) begin
            m_pal[m_idx] = {m_c[0], m_c[1], m_c[2]};
            m_pend = 0;
        end
        if (WR_EN && !pend_before && pal_we) model_write(pal_sel, pal_idx, pal_data);
        pq.push_back('{idx: pixel_color4, act: active, hs: hsync, vs: vsync,
                       hb: half_bright, col: 18'd0});
        o = pq.pop_front();
        #1;
        check("rgb",  32'({red, green, blue}), 32'(shade(o)));
        check("sync", 32'({hsync_o, vsync_o, active_o}), 32'({o.hs, o.vs, o.act}));
        check("busy", 32'(pal_busy), 32'(m_pend));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_rgb",  32'({red, green, blue}), 32'(0));
        check("rst_sync", 32'({hsync_o, vsync_o, active_o}), 32'(3'b110));
        check("rst_busy", 32'(pal_busy), 32'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [3:0] idx, input logic act, input logic hb);
        pixel_color4 = idx;
        active       = act;
        half_bright  = hb;
        hsync        = 1'b1;
        vsync        = 1'b1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] idx, input logic [5:0] d);
        pal_we   = 1'b1;
        pal_sel  = sel;
        pal_idx  = idx;
        pal_data = d;
        tick();
        pal_we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(4'd0, 1'b0, 1'b0);
        pal_we = 1'b0; pal_sel = 2'd0; pal_idx = 4'd0; pal_data = 6'd0;
        #1;
        do_reset();

        drive(4'd1, 1'b1, 1'b0);
        repeat (3) tick();
        check("white", 32'({red, green, blue}), 32'({6'd63, 6'd63, 6'd63}));
        check("white_act", 32'(active_o), 32'(1));
        drive(4'd1, 1'b1, 1'b1);
        repeat (3) tick();
        check("half_white", 32'({red, green, blue}), 32'({6'd31, 6'd31, 6'd31}));
        drive(4'd2, 1'b1, 1'b0);
        repeat (3) tick();
        check("idx2_default", 32'({red, green, blue}), 32'({6'd26, 6'd13, 6'd10}));
        drive(4'd1, 1'b0, 1'b0);
        repeat (3) tick();
        check("blank", 32'({red, green, blue}), 32'(0));

        drive(4'd5, 1'b1, 1'b0);
        hsync = 1'b0;
        tick();
        hsync = 1'b1;
        tick();
        check("hs_d2", 32'(hsync_o), 32'(1));
        tick();
        check("hs_d3", 32'(hsync_o), 32'(0));
        tick();
        check("hs_d4", 32'(hsync_o), 32'(1));

        // Write deferred while active, committed in blanking
        drive(4'd2, 1'b1, 1'b0);
        wr(2'd0, 4'd2, 6'd5);
        wr(2'd1, 4'd0, 6'd6);
        wr(2'd2, 4'd0, 6'd7);
        repeat (3) tick();
        check("busy_held", 32'(pal_busy), 32'(WR_EN));
        check("idx2_old", 32'({red, green, blue}), 32'({6'd26, 6'd13, 6'd10}));
        active = 1'b0;
        tick();
        active = 1'b1;
        tick();
        check("busy_fall", 32'(pal_busy), 32'(0));
        repeat (3) tick();
        check("idx2_new", 32'({red, green, blue}), 32'(EXP2));

        // Sequence errors, restart, and pulses ignored while pending
        wr(2'd0, 4'd3, 6'd1);
        wr(2'd2, 4'd0, 6'd2);
        wr(2'd1, 4'd0, 6'd3);
        wr(2'd2, 4'd0, 6'd4);
        check("seq_err_idle", 32'(pal_busy), 32'(0));
        wr(2'd0, 4'd4, 6'd9);
        wr(2'd0, 4'd5, 6'd10);
        wr(2'd1, 4'd0, 6'd11);
        wr(2'd2, 4'd0, 6'd12);
        wr(2'd0, 4'd6, 6'd1);
        wr(2'd1, 4'd0, 6'd1);
        wr(2'd2, 4'd0, 6'd1);
        check("busy_pend", 32'(pal_busy), 32'(WR_EN));
        drive(4'd0, 1'b0, 1'b0);
        tick();
        wr(2'd0, 4'd7, 6'd33);
        wr(2'd1, 4'd0, 6'd34);
        wr(2'd2, 4'd0, 6'd35);
        check("coincide_ignored", 32'(pal_busy), 32'(0));
        drive(4'd5, 1'b1, 1'b0);
        repeat (4) tick();
        check("idx5", 32'({red, green, blue}), 32'(EXP5));

        // Reset in the middle of a write and of a frame
        drive(4'd9, 1'b1, 1'b0);
        wr(2'd0, 4'd9, 6'd1);
        wr(2'd1, 4'd0, 6'd2);
        do_reset();
        wr(2'd2, 4'd0, 6'd3);
        repeat (4) tick();
        check("idx9_after_rst", 32'({red, green, blue}), 32'({6'd16, 6'd14, 6'd0}));
        check("busy_after_rst", 32'(pal_busy), 32'(0));

        for (int c = 0; c < 3000; c++) begin
            pixel_color4 = 4'($urandom);
            active       = (c % 50) < 38;
            hsync        = !((c % 50) >= 40 && (c % 50) < 45);
            vsync        = !(((c / 50) % 20) == 19);
            half_bright  = 1'($urandom_range(0, 1));
            pal_we       = ($urandom_range(0, 2) == 0);
            pal_sel      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_cnt);
            pal_idx      = 4'($urandom);
            pal_data     = 6'($urandom);
            if (c == 1500) do_reset();
            tick();
        end
        pal_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_color_pipe.md
Name: vga_color_pipe

Overview:
- Downstream of the hires VGA scan doubler; consumes its 4-bit colour index, active, hsync, vsync and half_bright.
- Produces 6-bit-per-component RGB for the VGA/HDMI encoder through a 16-entry palette RAM.
- Applies a half-bright scanline effect and blanks RGB outside the active area.
- Provides a register-side palette write port with a three-phase R/G/B handshake; commits are deferred to blanking to avoid tearing.

Parameters:
- PAL_DEPTH, 16: number of palette entries; index width is log2(PAL_DEPTH).
- COMP_W, 6: bits per colour component.

Ports:
- clk_dot8x  in  1  pixel clock, same clock as the scan doubler.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_color4  in  4  colour index from the scan doubler.
- active  in  1  active-area flag from the scan doubler.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- half_bright  in  1  scanline dim request.
- pal_we  in  1  palette write strobe, one cycle per component.
- pal_sel  in  2  component select: 0=R, 1=G, 2=B; 3 is reserved.
- pal_idx  in  4  palette entry index; sampled only with R.
- pal_data  in  COMP_W  component value.
- pal_busy  out  1  high while a completed write awaits commit.
- red, green, blue  out  COMP_W each  pixel colour.
- hsync_o, vsync_o  out  1 each  delayed sync, active low.
- active_o  out  1  delayed active flag.

Behaviour:
- Interface, as decided: one clock; reset is asynchronous and active-low.
- Reset values:
  - red, green, blue = 0; hsync_o = vsync_o = 1; active_o = 0.
  - pal_busy = 0; write FSM = IDLE.
  - Palette loads the default C64 colour table from the package.
  - Reset may be asserted mid-write; any partial or pending write is discarded.
- Pixel pipeline: three register stages, advancing every clk_dot8x; no stalls.
  - S1 registers index, active, hsync, vsync, half_bright.
  - S2 reads the palette synchronously; read-before-write.
  - S3 produces the output: red/green/blue = 0 if active is low; else the entry value, shifted right by 1 if half_bright is high.
  - Fixed latency: inputs at cycle n appear on all outputs at n+3. Syncs and active are delayed identically to RGB.
- Write FSM states: IDLE, GOT_R, GOT_G, PENDING.
  - IDLE: pal_we with sel=0 latches idx and R, goes to GOT_R. Any other sel is ignored.
  - GOT_R: pal_we with sel=1 latches G, goes to GOT_G.
  - GOT_G: pal_we with sel=2 latches B, goes to PENDING.
  - Sequence error in GOT_R/GOT_G: sel=0 restarts (latches new idx/R, goes to GOT_R); any other wrong sel drops to IDLE.
  - Cycles without pal_we hold state indefinitely.
  - PENDING: pal_busy = 1 and pal_we is ignored. The write commits on the first cycle where S1 active is low, then returns to IDLE with pal_busy = 0 the next cycle.
  - If pal_we and commit coincide in PENDING, pal_we is ignored.
- Commit during blanking: a same-index read in the commit cycle returns the old value. Its output is blanked anyway.
- Width rules:
  - Half-bright is a logical shift right; 63 becomes 31.
  - Index values at or above PAL_DEPTH wrap modulo PAL_DEPTH.

Optional Feature:
- Macro: VGA_PALETTE_WRITE_EN.
- Defined: the write FSM and palette RAM are present as described above.
- Undefined:
  - The palette is a constant ROM of the default table.
  - pal_we, pal_sel, pal_idx and pal_data are ignored.
  - pal_busy is tied to 0.
  - The pixel pipeline and its latency are unchanged.

Decomposition:
- Shared package holds:
  - the COMP_W constant;
  - an rgb_t struct (r, g, b);
  - a pal_sel enum (SEL_R, SEL_G, SEL_B);
  - the write-FSM state enum;
  - the 16-entry default palette constant, e.g. 0 = 0,0,0; 1 = 63,63,63; 2 = 26,13,10.
- Sub-module: palette_ram, a single-clock synchronous-read RAM with one write port and one read port, initialised from the package table.

Test Plan:
- Reset release, then pixel_color4=1, active=1, half_bright=0 -> after exactly 3 cycles, RGB = 63,63,63 and active_o = 1; hsync_o/vsync_o track the inputs with 3-cycle delay.
- Same as above with half_bright=1 -> RGB = 31,31,31. With active=0 -> RGB = 0,0,0 regardless of index.
- Write idx=2: R=5, G=6, B=7 while active=1 -> pal_busy = 1 and index 2 still yields 26,13,10. Drop active to 0 -> commit, pal_busy falls. Next active pixel of index 2 -> 5,6,7.
- Sequence error: sel R, then B -> FSM to IDLE, palette unchanged. Sel R, then R -> second R restarts the sequence with the new idx.
- pal_we pulses during PENDING -> ignored; the committed value is the first completed triple.
- Assert rst_n mid-write in GOT_G and mid-frame -> outputs return to reset values immediately; the palette holds defaults and pal_busy = 0. With VGA_PALETTE_WRITE_EN undefined, any write sequence leaves the output colours unchanged.
